// File: rtl/pet_bus_pkg.sv
// Shared types and defaults for the RAM bus arbiter between the CPU bus master and SPI1.
package pet_bus_pkg;

    localparam int PKG_ADDR_WIDTH = 17;
    localparam int PKG_DATA_WIDTH = 8;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_SPI = 1'b1
    } requester_t;

endpackage

// File: rtl/bus_strobe_timer.sv
// Loadable down-counter that times the RAM strobe window and flags its last cycle.
module bus_strobe_timer
    import pet_bus_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: non-blocking assignments let every register sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == '0);

endmodule

// File: rtl/spi_cpu_bus_arbiter.sv
// Shares the board RAM bus between the CPU bus master and the SPI1 transaction port.
// Optional SPI anti-starvation streak limit is built when ARB_FAIRNESS_EN is defined.
module spi_cpu_bus_arbiter
    import pet_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = PKG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = PKG_DATA_WIDTH,
    parameter int ACCESS_CYCLES  = 3,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cpu_req_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic                  cpu_rw_ni,
    input  logic [DATA_WIDTH-1:0] cpu_data_i,
    output logic [DATA_WIDTH-1:0] cpu_data_o,
    output logic                  cpu_ack_o,
    input  logic                  spi_valid_i,
    input  logic [ADDR_WIDTH-1:0] spi_addr_i,
    input  logic                  spi_rw_ni,
    input  logic [DATA_WIDTH-1:0] spi_data_i,
    output logic [DATA_WIDTH-1:0] spi_data_o,
    output logic                  spi_ready_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  ram_oe_o,
    output logic                  ram_we_o,
    output logic                  busy_o
);

    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
        $error("ACCESS_CYCLES must be in 1..15");
    end
    if (MAX_CPU_STREAK < 1 || MAX_CPU_STREAK > 15) begin : g_bad_streak
        $error("MAX_CPU_STREAK must be in 1..15");
    end

    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t            state_q, state_d;
    requester_t            winner_q, winner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rw_n_q, rw_n_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] spi_rdata_q, spi_rdata_d;
    logic                  cpu_armed_q, cpu_armed_d;
    logic                  spi_armed_q, spi_armed_d;

    logic cpu_pend;
    logic spi_pend;
    logic grant_spi;
    logic strobe_last;
    logic cpu_done;
    logic spi_done;

    assign cpu_pend = cpu_req_i & cpu_armed_q;
    assign spi_pend = spi_valid_i & spi_armed_q;
    assign cpu_done = (state_q == DONE) && (winner_q == REQ_CPU);
    assign spi_done = (state_q == DONE) && (winner_q == REQ_SPI);

`ifdef ARB_FAIRNESS_EN
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_CPU_STREAK);

    logic [CNT_W-1:0] streak_q, streak_d;

    assign grant_spi = spi_pend && (!cpu_pend || (streak_q == STREAK_MAX));

    // Only CPU grants that leave SPI waiting extend the streak.
    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (!spi_pend || grant_spi) begin
                streak_d = '0;
            end else begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign grant_spi = spi_pend && !cpu_pend;
`endif

    bus_strobe_timer u_strobe_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (state_q == SETUP),
        .load_val_i (STROBE_LOAD),
        .en_i       (state_q == STROBE),
        .last_o     (strobe_last)
    );

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        addr_d      = addr_q;
        rw_n_d      = rw_n_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        spi_rdata_d = spi_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_pend || spi_pend) begin
                    state_d = SETUP;
                    if (grant_spi) begin
                        winner_d = REQ_SPI;
                        addr_d   = spi_addr_i;
                        rw_n_d   = spi_rw_ni;
                        wdata_d  = spi_data_i;
                    end else begin
                        winner_d = REQ_CPU;
                        addr_d   = cpu_addr_i;
                        rw_n_d   = cpu_rw_ni;
                        wdata_d  = cpu_data_i;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                if (strobe_last) begin
                    state_d = DONE;
                    // Read data lands straight in the winner's output register so it shows in DONE.
                    if (rw_n_q) begin
                        if (winner_q == REQ_CPU) begin
                            cpu_rdata_d = ram_data_i;
                        end else begin
                            spi_rdata_d = ram_data_i;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A level held high after completion stays disarmed until it drops for a cycle.
    always_comb begin
        cpu_armed_d = cpu_armed_q;
        spi_armed_d = spi_armed_q;
        if (!cpu_req_i) begin
            cpu_armed_d = 1'b1;
        end else if (cpu_done) begin
            cpu_armed_d = 1'b0;
        end
        if (!spi_valid_i) begin
            spi_armed_d = 1'b1;
        end else if (spi_done) begin
            spi_armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            winner_q    <= REQ_CPU;
            addr_q      <= '0;
            rw_n_q      <= 1'b0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            spi_rdata_q <= '0;
            cpu_armed_q <= 1'b1;
            spi_armed_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            addr_q      <= addr_d;
            rw_n_q      <= rw_n_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            spi_rdata_q <= spi_rdata_d;
            cpu_armed_q <= cpu_armed_d;
            spi_armed_q <= spi_armed_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign ram_addr_o  = busy_o ? addr_q : '0;
    assign ram_data_o  = (busy_o && !rw_n_q) ? wdata_q : '0;
    assign ram_oe_o    = (state_q == STROBE) && rw_n_q;
    assign ram_we_o    = (state_q == STROBE) && !rw_n_q;
    assign cpu_ack_o   = cpu_done;
    assign spi_ready_o = spi_done;
    assign cpu_data_o  = cpu_rdata_q;
    assign spi_data_o  = spi_rdata_q;

endmodule
